// File: rtl/set_bit_enumerator_if.sv
// Handshake bundle for set_bit_enumerator.
//   in_valid/in_ready/in_mask : upstream word channel (one mask per handshake)
//   out_valid/out_ready       : downstream beat channel
//   out_index/out_ordinal/out_total/out_last/out_empty : per-beat payload
// slave  : the enumerator's view (accepts masks, produces beats)
// master : the surrounding logic's view (offers masks, consumes beats)
interface set_bit_enumerator_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = IDX_W + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [CNT_W-1:0] out_ordinal;
  logic [CNT_W-1:0] out_total;
  logic             out_last;
  logic             out_empty;

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_index, out_ordinal, out_total, out_last, out_empty
  );

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_index, out_ordinal, out_total, out_last, out_empty
  );
endinterface

// File: rtl/set_bit_enumerator.sv
// Set-bit enumerator: accepts one occupancy mask per handshake and emits the
// index of every set bit, lowest first, one beat per cycle. Each beat carries
// its ordinal among the set bits, the word's popcount and a last flag. An
// all-zero mask produces a single beat flagged empty.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-high reset
//   bus   : set_bit_enumerator_if.slave (input word channel + output beat channel)
module set_bit_enumerator #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = IDX_W + 1
) (
  input  logic                  clock,
  input  logic                  clear,
  set_bit_enumerator_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EMIT, ZERO} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] residual;
  logic [CNT_W-1:0] ordinal;
  logic [CNT_W-1:0] total;
  logic [WIDTH-1:0] residual_rest;
  logic             is_last;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(m[i]);
    return n;
  endfunction

  // Scanning downward lets the lowest set bit win the final assignment.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (m[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  // Dropping the lowest set bit: if nothing remains, this beat is the last.
  assign residual_rest = residual & (residual - WIDTH'(1));
  assign is_last       = (residual_rest == '0);

  always_comb begin
    state_nxt       = state;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_index   = '0;
    bus.out_ordinal = '0;
    bus.out_total   = '0;
    bus.out_last    = 1'b0;
    bus.out_empty   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = (bus.in_mask == '0) ? ZERO : EMIT;
      end
      EMIT: begin
        bus.out_valid   = 1'b1;
        bus.out_index   = lowest_set(residual);
        bus.out_ordinal = ordinal;
        bus.out_total   = total;
        bus.out_last    = is_last;
        if (bus.out_ready && is_last) state_nxt = IDLE;
      end
      ZERO: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_empty = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      residual <= '0;
      ordinal  <= '0;
      total    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            residual <= bus.in_mask;
            total    <= popcount(bus.in_mask);
            ordinal  <= '0;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            residual <= residual_rest;
            ordinal  <= is_last ? '0 : ordinal + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_bit_enumerator.sv
module tb_set_bit_enumerator;

  typedef struct packed {
    logic [4:0] idx;
    logic [5:0] ord;
    logic [5:0] tot;
    logic       last;
    logic       empty;
  } beat_t;

  logic  clock;
  logic  clear;
  int    n_checks;
  int    n_errors;
  int    beat_cnt;
  int    rdy_mode;  // 0: always ready, 1: toggle, 2: random, 3: never ready
  logic  rdy_tog;
  beat_t sb[$];

  logic        prev_stall;
  logic [4:0]  hold_idx;
  logic [5:0]  hold_ord;
  logic [5:0]  hold_tot;
  logic        hold_last;
  logic        hold_empty;

  set_bit_enumerator_if #(.WIDTH(32)) ifc ();

  set_bit_enumerator #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference expansion of a mask into its expected beats.
  task automatic push_expected(input logic [31:0] m);
    int pop;
    int ord;
    beat_t b;
    pop = 0;
    for (int i = 0; i < 32; i++) if (m[i]) pop++;
    if (pop == 0) begin
      b = '{idx: 5'd0, ord: 6'd0, tot: 6'd0, last: 1'b1, empty: 1'b1};
      sb.push_back(b);
    end else begin
      ord = 0;
      for (int i = 0; i < 32; i++) begin
        if (m[i]) begin
          b.idx   = 5'(i);
          b.ord   = 6'(ord);
          b.tot   = 6'(pop);
          b.last  = (ord == pop - 1);
          b.empty = 1'b0;
          sb.push_back(b);
          ord++;
        end
      end
    end
  endtask

  // out_ready generator, updated well after the edge so it never races the driver.
  always @(posedge clock) begin
    #2;
    rdy_tog = ~rdy_tog;
    case (rdy_mode)
      0:       ifc.out_ready = 1'b1;
      1:       ifc.out_ready = rdy_tog;
      2:       ifc.out_ready = 1'($urandom_range(0, 1));
      default: ifc.out_ready = 1'b0;
    endcase
  end

  // Output monitor: compares each accepted beat with the scoreboard head and
  // checks that a stalled beat is held unchanged.
  always @(negedge clock) begin
    beat_t e;
    if (clear) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ifc.out_valid) begin
        chk("stall_idx",   ifc.out_index,   hold_idx);
        chk("stall_ord",   ifc.out_ordinal, hold_ord);
        chk("stall_tot",   ifc.out_total,   hold_tot);
        chk("stall_last",  ifc.out_last,    hold_last);
        chk("stall_empty", ifc.out_empty,   hold_empty);
      end
      prev_stall = ifc.out_valid && !ifc.out_ready;
      hold_idx   = ifc.out_index;
      hold_ord   = ifc.out_ordinal;
      hold_tot   = ifc.out_total;
      hold_last  = ifc.out_last;
      hold_empty = ifc.out_empty;
      if (ifc.out_valid && ifc.out_ready) begin
        beat_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("idx",   ifc.out_index,   e.idx);
          chk("ord",   ifc.out_ordinal, e.ord);
          chk("tot",   ifc.out_total,   e.tot);
          chk("last",  ifc.out_last,    e.last);
          chk("empty", ifc.out_empty,   e.empty);
        end
      end
    end
  end

  // Offers a word and returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] m);
    bit done;
    done = 0;
    @(posedge clock);
    #1;
    ifc.in_valid = 1'b1;
    ifc.in_mask  = m;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clock);
      if (ifc.in_ready) begin
        push_expected(m);
        @(posedge clock);
        #1;
        ifc.in_valid = 1'b0;
        done = 1;
        chk("first_beat_valid", ifc.out_valid, 1'b1);
        chk("busy_not_ready",   ifc.in_ready,  1'b0);
      end
    end
    if (!done) begin
      chk("in_timeout", 32'd0, 32'd1);
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clock);
      if (sb.size() == 0 && !ifc.out_valid) done = 1;
    end
    chk("drain", done, 1'b1);
  endtask

  initial begin
    int base;
    logic [31:0] m;
    n_checks   = 0;
    n_errors   = 0;
    beat_cnt   = 0;
    rdy_mode   = 0;
    rdy_tog    = 1'b0;
    prev_stall = 1'b0;
    clear      = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_mask  = '0;

    // Reset state
    #1;
    chk("rst_valid",    ifc.out_valid,   1'b0);
    chk("rst_ready",    ifc.in_ready,    1'b1);
    chk("rst_index",    ifc.out_index,   5'd0);
    chk("rst_ordinal",  ifc.out_ordinal, 6'd0);
    chk("rst_total",    ifc.out_total,   6'd0);
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    chk("post_rst_valid", ifc.out_valid, 1'b0);
    chk("post_rst_ready", ifc.in_ready,  1'b1);

    // Single bit 0
    send_word(32'h0000_0001);
    @(posedge clock);
    #1;
    chk("t1_ready_again", ifc.in_ready, 1'b1);
    drain();

    // Bits 0, 2, 31
    send_word(32'h8000_0005);
    drain();

    // Empty word held, second word waits behind it
    rdy_mode = 3;
    send_word(32'h0000_0000);
    ifc.in_valid = 1'b1;
    ifc.in_mask  = 32'h0000_0010;
    repeat (3) @(posedge clock);
    #1;
    chk("t3_blocked", ifc.in_ready,  1'b0);
    chk("t3_empty",   ifc.out_empty, 1'b1);
    chk("t3_last",    ifc.out_last,  1'b1);
    chk("t3_index",   ifc.out_index, 5'd0);
    rdy_mode = 0;
    send_word(32'h0000_0010);
    drain();

    // All ones under toggled out_ready
    rdy_mode = 1;
    send_word(32'hFFFF_FFFF);
    drain();

    // Clear in the middle of a word
    rdy_mode = 0;
    base = beat_cnt;
    send_word(32'h00F0_0000);
    for (int c = 0; c < 50 && beat_cnt < base + 2; c++) begin
      @(posedge clock);
      #1;
    end
    chk("t5_two_beats", beat_cnt - base, 2);
    clear = 1'b1;
    #1;
    chk("t5_valid_drop", ifc.out_valid, 1'b0);
    @(posedge clock);
    #1;
    sb.delete();
    clear = 1'b0;
    #1;
    chk("t5_ready_after", ifc.in_ready,  1'b1);
    chk("t5_valid_after", ifc.out_valid, 1'b0);
    send_word(32'h0000_0002);
    drain();

    // Random masks with random out_ready
    rdy_mode = 2;
    for (int w = 0; w < 1000; w++) begin
      case (w % 4)
        0:       m = $urandom;
        1:       m = $urandom & $urandom;
        2:       m = $urandom & $urandom & $urandom;
        default: m = 32'h1 << $urandom_range(0, 31);
      endcase
      if (w % 97 == 0) m = 32'h0;
      send_word(m);
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
